// File: rtl/usr_reg_pkg.sv
// Shared definitions for the user-register sequencer: FSM state encoding,
// request-word width and a helper for the latency counter width.
package usr_reg_pkg;

    // Sequencer FSM states (2-bit encoding)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } seq_state_t;

    // Latency counter is wide enough for RD_LATENCY-1 with RD_LATENCY up to 7
    localparam int LAT_CNT_W = 3;

    // A queued request is packed as {we, addr, wdata}
    function automatic int req_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/usr_req_fifo.sv
// Small synchronous request FIFO. Head entry is presented combinationally on
// dout; push while full and pop while empty are ignored.
module usr_req_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             sys_clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_MAX);
    assign empty     = (count_r == {CW{1'b0}});
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign dout      = mem_r[rd_ptr_r];

    // Storage, pointers (wrap naturally, DEPTH is a power of two) and occupancy
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/usr_reg_seq.sv
// Upstream sequencer for the controller user-register port. Requests are
// queued, issued one at a time as single-cycle strobes, and read data is
// captured after a fixed latency and returned on a one-cycle response pulse.
module usr_reg_seq
    import usr_reg_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                  sys_clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic                  usr_ce,
    output logic                  usr_we,
    output logic [ADDR_WIDTH-1:0] usr_addr,
    output logic [DATA_WIDTH-1:0] usr_wdata,
    input  logic [DATA_WIDTH-1:0] usr_rdata
);

    localparam int RW = req_width(ADDR_WIDTH, DATA_WIDTH);
    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(RD_LATENCY - 1);
    localparam logic [LAT_CNT_W-1:0] LAT_ONE  = LAT_CNT_W'(1);

    seq_state_t            state_r;
    logic [LAT_CNT_W-1:0]  lat_cnt_r;
    logic                  usr_ce_r;
    logic                  usr_we_r;
    logic [ADDR_WIDTH-1:0] usr_addr_r;
    logic [DATA_WIDTH-1:0] usr_wdata_r;
    logic                  rsp_valid_r;
    logic [ADDR_WIDTH-1:0] rsp_addr_r;
    logic [DATA_WIDTH-1:0] rsp_rdata_r;

    logic                  push_s;
    logic                  pop_s;
    logic                  full_s;
    logic                  empty_s;
    logic [RW-1:0]         din_s;
    logic [RW-1:0]         dout_s;
    logic                  head_we_s;
    logic [ADDR_WIDTH-1:0] head_addr_s;
    logic [DATA_WIDTH-1:0] head_wdata_s;

    assign req_ready    = ~full_s;
    assign push_s       = req_valid & ~full_s;
    assign pop_s        = (state_r == ST_IDLE) & ~empty_s;
    assign din_s        = {req_we, req_addr, req_wdata};
    assign head_we_s    = dout_s[RW-1];
    assign head_addr_s  = dout_s[RW-2 -: ADDR_WIDTH];
    assign head_wdata_s = dout_s[DATA_WIDTH-1:0];
    assign busy         = ~empty_s | (state_r != ST_IDLE);

    assign usr_ce    = usr_ce_r;
    assign usr_we    = usr_we_r;
    assign usr_addr  = usr_addr_r;
    assign usr_wdata = usr_wdata_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_addr  = rsp_addr_r;
    assign rsp_rdata = rsp_rdata_r;

    usr_req_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .push    (push_s),
        .pop     (pop_s),
        .din     (din_s),
        .dout    (dout_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    // Sequencer FSM; strobe and response registers are loaded on the transition
    // into the state that presents them, so each lasts exactly one cycle
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            lat_cnt_r   <= {LAT_CNT_W{1'b0}};
            usr_ce_r    <= 1'b0;
            usr_we_r    <= 1'b0;
            usr_addr_r  <= {ADDR_WIDTH{1'b0}};
            usr_wdata_r <= {DATA_WIDTH{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_addr_r  <= {ADDR_WIDTH{1'b0}};
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rsp_valid_r <= 1'b0;
                    if (!empty_s) begin
                        usr_ce_r    <= 1'b1;
                        usr_we_r    <= head_we_s;
                        usr_addr_r  <= head_addr_s;
                        usr_wdata_r <= head_we_s ? head_wdata_s : {DATA_WIDTH{1'b0}};
                        state_r     <= ST_ISSUE;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    usr_ce_r    <= 1'b0;
                    usr_we_r    <= 1'b0;
                    usr_wdata_r <= {DATA_WIDTH{1'b0}};
                    if (usr_we_r) begin
                        state_r   <= ST_IDLE;
                    end else begin
                        lat_cnt_r <= LAT_INIT;
                        state_r   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt_r == {LAT_CNT_W{1'b0}}) begin
                        rsp_rdata_r <= usr_rdata;
                        rsp_addr_r  <= usr_addr_r;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end else begin
                        lat_cnt_r   <= lat_cnt_r - LAT_ONE;
                    end
                end
                ST_RESP: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    usr_ce_r    <= 1'b0;
                    usr_we_r    <= 1'b0;
                    usr_wdata_r <= {DATA_WIDTH{1'b0}};
                    rsp_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
